// File: rtl/switch_value_scheduler.sv
// Debounces a switch value and commits it to the display only at vsync fall (tear-free).
// Optional SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN adds an auto-increment mode driven by frames.
module switch_value_scheduler #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19,
    parameter int unsigned FRAMES_PER_STEP = 60
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_in,
    input  logic             vsync,
`ifdef SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN
    input  logic             auto_mode,
`endif
    output logic [WIDTH-1:0] value_out,
    output logic             update_pulse,
    output logic             pending
);

    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (FRAMES_PER_STEP == 0 || DEBOUNCE_CYCLES == 0) begin : g_bad_count
        $error("FRAMES_PER_STEP and DEBOUNCE_CYCLES must be non-zero");
    end

    typedef enum logic [1:0] {StIdle, StDebounce, StPending, StCommit} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   val_s1_q, s_val_q;
    logic               vs_s1_q, vs_s2_q, vs_d_q;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               upd_q, upd_d;
    logic               pending_q;
    logic               vs_fall;
    logic               change;

`ifdef SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN
    localparam int unsigned FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FC_W-1:0] FcMax = FC_W'(FRAMES_PER_STEP - 1);
    logic [FC_W-1:0] fc_q, fc_d;
`endif

    assign vs_fall = vs_d_q & ~vs_s2_q;
    assign change  = (s_val_q != cand_q);

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            val_s1_q <= '0;
            s_val_q  <= '0;
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            vs_d_q   <= 1'b0;
        end else begin
            val_s1_q <= value_in;
            s_val_q  <= val_s1_q;
            vs_s1_q  <= vsync;
            vs_s2_q  <= vs_s1_q;
            vs_d_q   <= vs_s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        upd_d   = 1'b0;
`ifdef SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN
        fc_d    = fc_q;
        if (auto_mode) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (vs_fall) begin
                if (fc_q == FcMax) begin
                    fc_d    = '0;
                    value_d = value_q + 1'b1;
                    upd_d   = 1'b1;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
            // Track value_out so leaving auto mode only commits a switch value that differs.
            cand_d = value_d;
        end else begin
            fc_d = '0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (change) begin
                        state_d = StDebounce;
                        cand_d  = s_val_q;
                        cnt_d   = '0;
                    end
                end
                StDebounce: begin
                    if (change) begin
                        cand_d = s_val_q;
                        cnt_d  = '0;
                    end else if (cnt_q == CntMax) begin
                        // A glitch that settled back on the shown value needs no commit.
                        state_d = (cand_q != value_q) ? StPending : StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPending: begin
                    // A fresh input change outranks a coincident frame boundary.
                    if (change) begin
                        state_d = StDebounce;
                        cand_d  = s_val_q;
                        cnt_d   = '0;
                    end else if (vs_fall) begin
                        state_d = StCommit;
                    end
                end
                StCommit: begin
                    value_d = cand_q;
                    upd_d   = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
`ifdef SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN
        end
`endif
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cand_q    <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            upd_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            upd_q     <= upd_d;
            pending_q <= (state_d == StPending);
        end
    end

`ifdef SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end
`endif

    assign value_out    = value_q;
    assign update_pulse = upd_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_switch_value_scheduler.sv
// Directed bench for switch_value_scheduler with a commit scoreboard.
// Covers the auto-cycle mode when SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN is defined.
module tb_switch_value_scheduler;

    localparam int unsigned WIDTH = 4;
    localparam int FRAME = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] value_in;
    logic             vsync = 1'b1;
    logic             auto_mode;
    logic [WIDTH-1:0] value_out;
    logic             update_pulse;
    logic             pending;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    int tick = 1;
    logic [WIDTH-1:0] exp_q[$];

    switch_value_scheduler #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(3),
        .FRAMES_PER_STEP(2)
    ) dut (
        .clk_50MHz(clk),
        .reset(reset),
        .value_in(value_in),
        .vsync(vsync),
`ifdef SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN
        .auto_mode(auto_mode),
`endif
        .value_out(value_out),
        .update_pulse(update_pulse),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // vsync is low for ticks 0..3 of every 200-cycle frame.
    always @(posedge clk) begin
        #1;
        tick  = (tick == FRAME - 1) ? 0 : tick + 1;
        vsync = (tick >= 4);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && update_pulse) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("unexpected_pulse", 32'(value_out), 32'hdead);
            else check("commit_value", 32'(value_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (tick != 0 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tick == 0), 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input int max_cyc, output int waited);
        logic seen = 1'b0;
        waited = 0;
        while (!seen && waited < max_cyc) begin
            @(negedge clk);
            waited++;
            seen = update_pulse;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int w;
        int base;
        logic seen;

        reset = 1'b1;
        value_in = '0;
        auto_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value_out", 32'(value_out), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_update", 32'(update_pulse), 32'd0);
        drive_step();
        reset = 1'b0;

        // Idle for 3 frames: nothing may happen.
        seen = 1'b0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            seen |= pending;
        end
        check("idle_pulses", 32'(pulse_cnt), 32'd0);
        check("idle_pending", 32'(seen), 32'd0);
        check("idle_value", 32'(value_out), 32'd0);

        // 0 -> 5, committed at the next frame boundary.
        wait_fall("fall_a");
        repeat (10) drive_step();
        value_in = 4'd5;
        exp_q.push_back(4'd5);
        repeat (12) @(negedge clk);
        check("pending_5", 32'(pending), 32'd1);
        check("no_early_5", 32'(value_out), 32'd0);
        wait_pulse("pulse_5", 2 * FRAME, w);
        @(negedge clk);
        check("after_5_pending", 32'(pending), 32'd0);
        check("after_5_value", 32'(value_out), 32'd5);
        check("after_5_count", 32'(pulse_cnt), 32'd1);

        // Short glitch 5 -> 3 -> 5: no pending, no update.
        drive_step();
        value_in = 4'd3;
        repeat (4) drive_step();
        value_in = 4'd5;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= pending;
        end
        check("glitch_pending", 32'(seen), 32'd0);
        check("glitch_pulses", 32'(pulse_cnt), 32'd1);
        check("glitch_value", 32'(value_out), 32'd5);

        // Pending 7, then 9 arrives with the vsync fall: 7 never commits, 9 one frame later.
        wait_fall("fall_b");
        repeat (5) drive_step();
        value_in = 4'd7;
        repeat (20) @(negedge clk);
        check("pending_7", 32'(pending), 32'd1);
        while (tick != FRAME - 1) @(negedge clk);
        drive_step();
        value_in = 4'd9;
        exp_q.push_back(4'd9);
        wait_pulse("pulse_9", 2 * FRAME + 50, w);
        check("pulse_9_next_frame", 32'(w > 150), 32'd1);
        check("value_9", 32'(value_out), 32'd9);

        // Reset while pending A: immediate clear, then A commits after release.
        wait_fall("fall_c");
        repeat (5) drive_step();
        value_in = 4'hA;
        repeat (15) @(negedge clk);
        check("pending_a", 32'(pending), 32'd1);
        drive_step();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_value", 32'(value_out), 32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        repeat (2) drive_step();
        reset = 1'b0;
        exp_q.push_back(4'hA);
        wait_pulse("pulse_a", 2 * FRAME + 50, w);
        check("value_a", 32'(value_out), 32'hA);

`ifdef SWITCH_VALUE_SCHEDULER_AUTO_CYCLE_EN
        drive_step();
        value_in = 4'hE;
        exp_q.push_back(4'hE);
        wait_pulse("pulse_e", 2 * FRAME + 50, w);
        drive_step();
        auto_mode = 1'b1;
        value_in = 4'h3;
        base = pulse_cnt;
        exp_q.push_back(4'hF);
        wait_pulse("auto_15", 2 * FRAME + 50, w);
        exp_q.push_back(4'h0);
        wait_pulse("auto_0", 2 * FRAME + 50, w);
        check("auto_step_gap", 32'(w >= 2 * FRAME - 5 && w <= 2 * FRAME + 5), 32'd1);
        check("auto_pulses", 32'(pulse_cnt - base), 32'd2);
        check("auto_pending", 32'(pending), 32'd0);
        drive_step();
        auto_mode = 1'b0;
        exp_q.push_back(4'h3);
        wait_pulse("resume_3", 2 * FRAME + 50, w);
        check("resume_value", 32'(value_out), 32'h3);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
